rect_frame_ctrl: RTL and testbench

- Frame-synchronous controller for the rectangle coordinates (x0, x1, y0, y1) consumed by the VGA rectangle renderer.
- Host writes go into shadow registers. These are validated and committed atomically on the rising edge of vsync, so the visible box never tears mid-frame.
- An optional auto-move mode steps the box by a signed per-frame velocity and bounces it off the screen edges.
- Sits between the CPU/CSR bus and the renderer's coordinate inputs, in the renderer's clock domain.

---
 rtl/rect_frame_ctrl.sv | 174 +++++++++++++++++
 tb/tb_rect_frame_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_frame_ctrl.sv
// ---------------------------------------------------------------------------
// rect_frame_ctrl
//
// Frame-synchronous coordinate controller for the VGA rectangle renderer.
// Host writes land in shadow registers. On each rising edge of vsync they are
// validated and committed as one unit, so the visible box never tears
// mid-frame. When auto-move is enabled and nothing is pending, the box is
// stepped by a signed per-frame velocity instead, bouncing off the screen
// edges.
//
// Ports:
//   clk          pixel/system clock (same domain as the sync generator)
//   reset_n      asynchronous active-low reset
//   vsync        vertical sync, synchronous to clk
//   wr_valid     host write request
//   wr_ready     write can be accepted this cycle (IDLE only)
//   wr_addr      0=X0 1=X1 2=Y0 3=Y1 4=DX 5=DY 6=CTRL(bit0 auto_en) 7=ignored
//   wr_data      signed write data
//   x0,x1,y0,y1  signed active coordinates to the renderer
//   frame_tick   one-cycle pulse when the per-frame update completes
//   cfg_err      sticky: the last commit attempt was rejected
// ---------------------------------------------------------------------------
module rect_frame_ctrl #(
    parameter int H_RES = 320,
    parameter int V_RES = 480
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               vsync,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [2:0]         wr_addr,
    input  logic [15:0]        wr_data,
    output logic signed [15:0] x0,
    output logic signed [15:0] x1,
    output logic signed [15:0] y0,
    output logic signed [15:0] y1,
    output logic               frame_tick,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        MOVE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic signed [16:0] H_LIM = 17'(H_RES);
    localparam logic signed [16:0] V_LIM = 17'(V_RES);

    state_t state;
    state_t state_next;

    logic               vsync_d;
    logic               vsync_edge;
    logic               wr_fire;
    logic               pending;
    logic               auto_en;
    logic               box_ok;
    logic signed [15:0] sx0, sx1, sy0, sy1;
    logic signed [15:0] dx, dy;
    logic signed [16:0] nx0, nx1, ny0, ny1;
    logic               bounce_x, bounce_y;

    assign vsync_edge = vsync & ~vsync_d;
    assign wr_fire    = wr_valid & wr_ready;
    assign box_ok     = (sx0 < sx1) && (sy0 < sy1);

    // Candidate positions use one extra bit so an edge crossing cannot wrap.
    always_comb begin
        nx0      = {x0[15], x0} + {dx[15], dx};
        nx1      = {x1[15], x1} + {dx[15], dx};
        ny0      = {y0[15], y0} + {dy[15], dy};
        ny1      = {y1[15], y1} + {dy[15], dy};
        bounce_x = nx0[16] || (nx1 > H_LIM);
        bounce_y = ny0[16] || (ny1 > V_LIM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A commit consumes the frame, so motion is only attempted when nothing
    // was pending. Edges outside IDLE are ignored.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (vsync_edge) state_next = COMMIT;
            COMMIT:  state_next = (!pending && auto_en) ? MOVE : DONE;
            MOVE:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_ready   = (state == IDLE);
        frame_tick = (state == DONE);
    end

    // Writes are only accepted in IDLE, so they never collide with the
    // COMMIT/MOVE updates of the same registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_d <= 1'b0;
            pending <= 1'b0;
            auto_en <= 1'b0;
            cfg_err <= 1'b0;
            sx0     <= '0;
            sx1     <= '0;
            sy0     <= '0;
            sy1     <= '0;
            dx      <= '0;
            dy      <= '0;
            x0      <= '0;
            x1      <= '0;
            y0      <= '0;
            y1      <= '0;
        end else begin
            vsync_d <= vsync;

            if (wr_fire) begin
                case (wr_addr)
                    3'd0: begin sx0 <= wr_data; pending <= 1'b1; end
                    3'd1: begin sx1 <= wr_data; pending <= 1'b1; end
                    3'd2: begin sy0 <= wr_data; pending <= 1'b1; end
                    3'd3: begin sy1 <= wr_data; pending <= 1'b1; end
                    3'd4: dx      <= wr_data;
                    3'd5: dy      <= wr_data;
                    3'd6: auto_en <= wr_data[0];
                    default: ;
                endcase
            end

            case (state)
                COMMIT: begin
                    if (pending) begin
                        pending <= 1'b0;
                        if (box_ok) begin
                            x0      <= sx0;
                            x1      <= sx1;
                            y0      <= sy0;
                            y1      <= sy1;
                            cfg_err <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                MOVE: begin
                    if (bounce_x) begin
                        dx <= -dx;
                    end else begin
                        x0 <= nx0[15:0];
                        x1 <= nx1[15:0];
                    end
                    if (bounce_y) begin
                        dy <= -dy;
                    end else begin
                        y0 <= ny0[15:0];
                        y1 <= ny1[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rect_frame_ctrl
//
// Self-checking bench for rect_frame_ctrl: a table of commit vectors with
// hand-computed results, hand-written sequences for auto-move, bounce,
// edge-cycle writes, stalls and mid-frame reset, then randomized frames
// checked against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_rect_frame_ctrl;

    localparam int H_RES = 320;
    localparam int V_RES = 480;

    logic               clk;
    logic               reset_n;
    logic               vsync;
    logic               wr_valid;
    logic               wr_ready;
    logic [2:0]         wr_addr;
    logic [15:0]        wr_data;
    logic signed [15:0] x0, x1, y0, y1;
    logic               frame_tick;
    logic               cfg_err;

    int checks = 0;
    int errors = 0;

    // Reference model state, kept as plain integers.
    int m_x0, m_x1, m_y0, m_y1;
    int m_sx0, m_sx1, m_sy0, m_sy1;
    int m_dx, m_dy;
    int m_auto, m_pend, m_err;

    rect_frame_ctrl #(.H_RES(H_RES), .V_RES(V_RES)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vsync      (vsync),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .x0         (x0),
        .x1         (x1),
        .y0         (y0),
        .y1         (y1),
        .frame_tick (frame_tick),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        int wx0, wx1, wy0, wy1;
        int ex0, ex1, ey0, ey1;
        int eerr;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_coords(input string name, input int e0, input int e1,
                                input int e2, input int e3);
        check_output({name, "_x0"}, int'(x0), e0);
        check_output({name, "_x1"}, int'(x1), e1);
        check_output({name, "_y0"}, int'(y0), e2);
        check_output({name, "_y1"}, int'(y1), e3);
    endtask

    function automatic void model_reset();
        m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
        m_sx0 = 0; m_sx1 = 0; m_sy0 = 0; m_sy1 = 0;
        m_dx = 0; m_dy = 0;
        m_auto = 0; m_pend = 0; m_err = 0;
    endfunction

    function automatic void model_write(input int a, input int d);
        case (a)
            0: begin m_sx0 = d; m_pend = 1; end
            1: begin m_sx1 = d; m_pend = 1; end
            2: begin m_sy0 = d; m_pend = 1; end
            3: begin m_sy1 = d; m_pend = 1; end
            4: m_dx = d;
            5: m_dy = d;
            6: m_auto = d & 1;
            default: ;
        endcase
    endfunction

    // Applies one frame's worth of behaviour; returns the number of busy cycles.
    function automatic int model_frame();
        if (m_pend != 0) begin
            if (m_sx0 < m_sx1 && m_sy0 < m_sy1) begin
                m_x0 = m_sx0; m_x1 = m_sx1; m_y0 = m_sy0; m_y1 = m_sy1;
                m_err = 0;
            end else begin
                m_err = 1;
            end
            m_pend = 0;
            return 2;
        end
        if (m_auto != 0) begin
            if (m_x0 + m_dx < 0 || m_x1 + m_dx > H_RES) begin
                m_dx = -m_dx;
            end else begin
                m_x0 += m_dx; m_x1 += m_dx;
            end
            if (m_y0 + m_dy < 0 || m_y1 + m_dy > V_RES) begin
                m_dy = -m_dy;
            end else begin
                m_y0 += m_dy; m_y1 += m_dy;
            end
            return 3;
        end
        return 2;
    endfunction

    task automatic apply_stimulus(input int a, input int d);
        int n;
        n        = 0;
        wr_valid = 1'b1;
        wr_addr  = 3'(a);
        wr_data  = 16'(d);
        while (!wr_ready && n < 20) begin
            step();
            n++;
        end
        check_output("wr_ready_wait", int'(wr_ready), 1);
        step();
        wr_valid = 1'b0;
        model_write(a, d);
    endtask

    // Raises vsync, follows the busy window and checks timing plus results.
    task automatic do_frame();
        int ox0, ox1, oy0, oy1;
        int len, n, ticks, tick_pos;
        ox0 = m_x0; ox1 = m_x1; oy0 = m_y0; oy1 = m_y1;
        vsync = 1'b1;
        step();
        len      = model_frame();
        n        = 0;
        ticks    = 0;
        tick_pos = -1;
        check_coords("frame_hold", ox0, ox1, oy0, oy1);
        while (!wr_ready && n < 10) begin
            if (frame_tick) begin
                ticks++;
                tick_pos = n;
                check_output("tick_cycle_x0", int'(x0), m_x0);
                check_output("tick_cycle_y0", int'(y0), m_y0);
            end
            n++;
            step();
        end
        check_output("busy_cycles", n, len);
        check_output("tick_count", ticks, 1);
        check_output("tick_position", tick_pos, len - 1);
        check_output("tick_idle", int'(frame_tick), 0);
        check_coords("frame", m_x0, m_x1, m_y0, m_y1);
        check_output("cfg_err", int'(cfg_err), m_err);
        vsync = 1'b0;
        step();
        step();
    endtask

    initial begin
        vec_t vecs[6];
        int   prev_x0;
        int   stalls;
        int   len;
        int   exp_x0[4];

        vecs[0] = '{10, 50, 20, 60, 10, 50, 20, 60, 0};
        vecs[1] = '{100, 40, 20, 60, 10, 50, 20, 60, 1};
        vecs[2] = '{5, 6, 7, 8, 5, 6, 7, 8, 0};
        vecs[3] = '{-5, 5, -3, 3, -5, 5, -3, 3, 0};
        vecs[4] = '{0, 0, 1, 2, -5, 5, -3, 3, 1};
        vecs[5] = '{10, 50, 20, 60, 10, 50, 20, 60, 0};
        exp_x0  = '{13, 16, 19, 22};

        reset_n  = 1'b0;
        vsync    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_coords("reset", 0, 0, 0, 0);
        check_output("reset_wr_ready", int'(wr_ready), 1);
        check_output("reset_frame_tick", int'(frame_tick), 0);
        check_output("reset_cfg_err", int'(cfg_err), 0);
        reset_n = 1'b1;
        step();
        step();
        check_output("post_reset_wr_ready", int'(wr_ready), 1);

        // Table of commit vectors with hand-computed results.
        prev_x0 = 0;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, vecs[i].wx0);
            apply_stimulus(1, vecs[i].wx1);
            apply_stimulus(2, vecs[i].wy0);
            apply_stimulus(3, vecs[i].wy1);
            check_output("shadow_not_visible", int'(x0), prev_x0);
            do_frame();
            check_coords("vec", vecs[i].ex0, vecs[i].ex1, vecs[i].ey0, vecs[i].ey1);
            check_output("vec_cfg_err", int'(cfg_err), vecs[i].eerr);
            prev_x0 = vecs[i].ex0;
        end

        // Auto-move stepping by DX=3 from x=10..50.
        apply_stimulus(4, 3);
        apply_stimulus(6, 1);
        for (int f = 0; f < 4; f++) begin
            do_frame();
            check_output("auto_step_x0", int'(x0), exp_x0[f]);
            check_output("auto_step_x1", int'(x1), exp_x0[f] + 40);
        end

        // Bounce off the right edge.
        apply_stimulus(0, 300);
        apply_stimulus(1, 318);
        do_frame();
        check_output("bounce_commit_x0", int'(x0), 300);
        apply_stimulus(4, 4);
        do_frame();
        check_output("bounce_hold_x0", int'(x0), 300);
        check_output("bounce_hold_x1", int'(x1), 318);
        do_frame();
        check_output("bounce_back_x0", int'(x0), 296);
        check_output("bounce_back_x1", int'(x1), 314);

        // Write presented in the vsync edge cycle joins that commit.
        vsync    = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 3'd0;
        wr_data  = 16'd0;
        check_output("edge_write_ready", int'(wr_ready), 1);
        step();
        wr_valid = 1'b0;
        model_write(0, 0);
        len = model_frame();
        check_output("edge_commit_busy", int'(wr_ready), 0);
        check_output("edge_commit_hold_x0", int'(x0), 296);
        step();
        check_output("edge_done_tick", int'(frame_tick), 1);
        check_output("edge_done_x0", int'(x0), 0);
        check_output("edge_done_x1", int'(x1), 318);
        step();
        check_output("edge_move_skipped", len, 2);
        check_output("edge_idle_ready", int'(wr_ready), 1);
        check_output("edge_idle_tick", int'(frame_tick), 0);
        vsync = 1'b0;
        repeat (3) step();

        // Write raised during COMMIT stalls until IDLE.
        vsync = 1'b1;
        step();
        len      = model_frame();
        wr_valid = 1'b1;
        wr_addr  = 3'd1;
        wr_data  = 16'd200;
        stalls   = 0;
        while (!wr_ready && stalls < 10) begin
            stalls++;
            step();
        end
        check_output("stall_cycles", stalls, len);
        step();
        wr_valid = 1'b0;
        model_write(1, 200);
        check_output("stall_not_committed_x1", int'(x1), 318);
        vsync = 1'b0;
        repeat (3) step();
        do_frame();
        check_output("stall_commit_x1", int'(x1), 200);

        // Reset asserted during MOVE.
        vsync = 1'b1;
        step();
        check_output("pre_reset_busy", int'(wr_ready), 0);
        step();
        reset_n = 1'b0;
        vsync   = 1'b0;
        #1;
        check_coords("async_reset", 0, 0, 0, 0);
        check_output("async_reset_tick", int'(frame_tick), 0);
        for (int k = 0; k < 2; k++) begin
            step();
            check_output("reset_hold_tick", int'(frame_tick), 0);
        end
        reset_n = 1'b1;
        model_reset();
        step();
        check_output("release_wr_ready", int'(wr_ready), 1);
        check_coords("release", 0, 0, 0, 0);
        check_output("release_cfg_err", int'(cfg_err), 0);
        step();

        // Randomized frames against the reference model.
        for (int f = 0; f < 40; f++) begin
            int nw;
            nw = int'($urandom_range(0, 4));
            for (int w = 0; w < nw; w++) begin
                int a, d;
                a = int'($urandom_range(0, 7));
                if (a <= 3) d = int'($urandom_range(0, 540)) - 20;
                else if (a <= 5) d = int'($urandom_range(0, 16)) - 8;
                else if (a == 6) d = int'($urandom_range(0, 3));
                else d = int'($urandom_range(0, 1000));
                apply_stimulus(a, d);
            end
            do_frame();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
